// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-box, Rcon, GF(2^8) doubling and FSM state encoding.
package aes_pkg;
  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUND = 2'd1, ST_DONE = 2'd2} state_t;

  // Forward S-box; entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction
endpackage

// File: rtl/aes_round_step.sv
// One combinational AES-128 round plus the matching key-schedule step.
module aes_round_step
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [BLOCK_W-1:0] key,
  input  logic [3:0]         round_num,
  input  logic               is_final,
  output logic [BLOCK_W-1:0] next_block,
  output logic [BLOCK_W-1:0] next_key
);
  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] w0, w1, w2, w3, tmp, n0, n1, n2, n3;

  always_comb begin
    w0  = key[127:96];
    w1  = key[95:64];
    w2  = key[63:32];
    w3  = key[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
          ^ {rcon(round_num), 24'h0};
    n0  = w0 ^ tmp;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Byte i is column i/4, row i%4; row 0 is the MSB byte of each column.
  always_comb begin
    sb = '{default: '0};
    sr = '{default: '0};
    mc = '{default: '0};
    next_block = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(block[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gm2(sr[4*c]) ^ gm3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gm2(sr[4*c+1]) ^ gm3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gm2(sr[4*c+2]) ^ gm3(sr[4*c+3]);
      mc[4*c+3] = gm3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gm2(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      next_block[127-8*i -: 8] = (is_final ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [aes_pkg::BLOCK_W-1:0] in_block,
  input  logic [aes_pkg::BLOCK_W-1:0] in_key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [aes_pkg::BLOCK_W-1:0] out_block,
  output logic                       busy,
  output logic [3:0]                 round_num
);
  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NR);

  state_t             state;
  logic [BLOCK_W-1:0] block_reg, key_reg, step_block, step_key;

  aes_round_step u_step (
    .block      (block_reg),
    .key        (key_reg),
    .round_num  (round_num),
    .is_final   (round_num == LAST),
    .next_block (step_block),
    .next_key   (step_key)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ROUND);
  assign out_block = block_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      round_num <= '0;
      block_reg <= '0;
      key_reg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          round_num <= '0;
          if (in_valid) begin
            block_reg <= in_block ^ in_key;
            key_reg   <= in_key;
            round_num <= 4'd1;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          // A corrupted round counter abandons the block rather than running on.
          if (round_num == 4'd0 || round_num > LAST) begin
            state     <= ST_IDLE;
            round_num <= '0;
          end else begin
            block_reg <= step_block;
            key_reg   <= step_key;
            if (round_num == LAST) state <= ST_DONE;
            else                   round_num <= round_num + 4'd1;
          end
        end
        ST_DONE: begin
          if (round_num != LAST || out_ready) begin
            state     <= ST_IDLE;
            round_num <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          round_num <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vectors, random blocks against a GF(2^8) reference model.
module tb_aes_round_sequencer;
  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_block, in_key, out_block;
  logic [3:0]   round_num;

  int n_chk = 0;
  int n_err = 0;

  aes_round_sequencer #(.NR(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy), .round_num(round_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] sbt[256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built from field arithmetic, independent of any lookup table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    if (x == 8'h00) v = 8'h00;
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a[4];
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] res = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts and ends just after a falling edge, with the sequencer idle.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input bit scramble, input int hold);
    int n;
    logic [127:0] ct;
    in_valid = 1'b1; in_block = pt; in_key = key; out_ready = 1'b0;
    chk({tag, " in_ready_idle"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 15) begin
      if (n < 10) begin
        chk({tag, " round_num"}, round_num, n + 1);
        chk({tag, " busy"}, busy, 1);
      end
      if (scramble) begin
        in_valid = 1'($urandom); in_block = rnd128(); in_key = rnd128();
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, " latency"}, n, 10);
    chk({tag, " out_block"}, out_block, exp);
    chk({tag, " in_ready_done"}, in_ready, 0);
    chk({tag, " round_num_done"}, round_num, 10);
    ct = out_block;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_block"}, out_block, ct);
      chk({tag, " hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle_after_hs"}, {out_valid, in_ready, busy}, 3'b010);
    chk({tag, " round_num_idle"}, round_num, 0);
  endtask

  initial begin
    int acc, got, cnt;
    int acc_edge[2];
    logic [127:0] outs[2];

    for (int i = 0; i < 256; i++) sbt[i] = calc_sbox(8'(i));
    tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 6; i++) begin
      tbl[i].key = rnd128();
      tbl[i].pt  = rnd128();
      tbl[i].ct  = ref_aes(tbl[i].pt, tbl[i].key);
    end

    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_block = tbl[0].pt; in_key = tbl[0].key;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, busy, round_num}, {1'b1, 1'b0, 1'b0, 4'd0});
    chk("reset_block", out_block, 0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_block($sformatf("vec%0d", i), tbl[i].pt, tbl[i].key, tbl[i].ct, 1'b0, 0);

    run_block("hold", tbl[1].pt, tbl[1].key, tbl[1].ct, 1'b0, 5);

    for (int i = 0; i < 4; i++) begin
      logic [127:0] k, p;
      k = rnd128(); p = rnd128();
      run_block($sformatf("scramble%0d", i), p, k, ref_aes(p, k), 1'b1, 0);
    end

    // Abandon a block mid-flight, then present a new one immediately after reset.
    in_valid = 1'b1; in_block = tbl[2].pt; in_key = tbl[2].key;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (round_num != 4'd5 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("reach_round5", round_num, 5);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0;
    chk("mid_reset_state", {in_ready, out_valid, busy, round_num}, {1'b1, 1'b0, 1'b0, 4'd0});
    run_block("post_reset", tbl[0].pt, tbl[0].key, tbl[0].ct, 1'b0, 0);

    // Back-to-back with in_valid held high and out_ready tied high.
    acc = 0; got = 0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    outs[0] = '0; outs[1] = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (out_valid) begin outs[got] = out_block; got++; end
      if (in_ready) begin
        if (acc < 2) begin
          in_block = tbl[acc].pt; in_key = tbl[acc].key;
          acc_edge[acc] = c; acc++;
        end else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_outputs", got, 2);
    chk("b2b_spacing", acc_edge[1] - acc_edge[0], 12);
    chk("b2b_ct0", outs[0], tbl[0].ct);
    chk("b2b_ct1", outs[1], tbl[1].ct);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  plaintext and key present.
REQ-005 SHALL have port in_ready  output  1  sequencer accepts a new block.
REQ-006 SHALL have port in_block  input  128  plaintext; column 0 is bits [127:96], row 0 of each column is the MSB byte.
REQ-007 SHALL have port in_key  input  128  cipher key, same byte order as in_block.
REQ-008 SHALL have port out_valid  output  1  ciphertext available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the ciphertext.
REQ-010 SHALL have port out_block  output  128  ciphertext.
REQ-011 SHALL have port busy  output  1  high in ROUND state.
REQ-012 SHALL have port round_num  output  4  current round index, for debug.

Function
REQ-013 SHALL implement an FSM with states IDLE, ROUND and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept occurs on a clock edge where in_valid and in_ready are both 1.
REQ-015 On accept SHALL load block_reg<=in_block^in_key, key_reg<=in_key and round_num<=1, then go to ROUND.
REQ-016 Each ROUND edge SHALL compute the next key from key_reg using rot/sub word and Rcon[round_num], with Rcon for rounds 1..10 = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte; it SHALL load the result into key_reg.
REQ-017 For round_num 1..9, each ROUND edge SHALL load block_reg<=MixColumns(ShiftRows(SubBytes(block_reg)))^next_key and increment round_num.
REQ-018 For round_num==10, the ROUND edge SHALL load block_reg<=ShiftRows(SubBytes(block_reg))^next_key and go to DONE.
REQ-019 Latency SHALL be exactly 10 cycles: with accept on edge E0, out_valid is first high after edge E10.
REQ-020 In DONE, out_valid SHALL be 1; out_block (=block_reg) and out_valid SHALL hold stable until out_valid&out_ready.
REQ-021 On the edge where out_valid&out_ready, the FSM SHALL go to IDLE.
REQ-022 in_ready SHALL be 0 in DONE, so a new accept happens at the earliest one cycle after the handshake; there is no same-cycle turnaround.
REQ-023 in_valid, in_block and in_key SHALL be ignored outside IDLE; inputs changing mid-encryption SHALL NOT affect the result.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 round_num SHALL be 0 in IDLE, 1..10 in ROUND, and 10 in DONE.
REQ-026 The round_num wrap-around check SHALL never let it exceed 10; an illegal FSM state or round_num SHALL recover to IDLE on the next edge.

Reset
REQ-027 On a reset edge the sequencer SHALL go to IDLE and set round_num=0, out_valid=0, busy=0, in_ready=1, block_reg=0 and key_reg=0.
REQ-028 Reset mid-encryption or in DONE SHALL abandon the block without emitting it.
REQ-029 A block presented in the first cycle after reset deasserts SHALL be accepted.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.

Structure
REQ-031 A shared package aes_pkg SHALL hold the S-box function, the Rcon table, the xtime/gm2/gm3 helpers, the FSM state enumeration, and the constants NR=10 and BLOCK_W=128.
REQ-032 One combinational sub-module aes_round_step SHALL be used, with inputs block, key, round_num and is_final, and outputs next_block and next_key.
REQ-033 The sequencer SHALL own all registers and the FSM; aes_round_step SHALL contain no state.

Verification
REQ-034 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid after exactly 10 cycles.
REQ-035 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; round_num steps 1..10 and busy is high for 10 cycles.
REQ-036 out_ready held 0 for 5 cycles after out_valid -> out_block and out_valid stable, in_ready=0 throughout; on out_ready=1, IDLE follows next cycle.
REQ-037 Reset pulsed when round_num=5 -> next cycle IDLE, round_num=0, out_valid=0; a subsequent FIPS-197 vector still encrypts correctly.
REQ-038 in_block and in_key randomized every cycle during ROUND -> ciphertext matches the vector captured at accept.
REQ-039 Two back-to-back blocks with in_valid held high and out_ready tied 1 -> the two accepts are 12 edges apart, and both ciphertexts are correct.
